// File: rtl/music_seq_if.sv
// Song-memory read port and sound-effect request channel of the music sequencer.
// master = sequencer side, slave = memory / effect requester side.
interface music_seq_if #(
  parameter int ADDR_W = 8
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              sfx_req;
  logic [7:0]        sfx_note;
  logic [3:0]        sfx_ticks;
  logic              sfx_ack;

  modport master (
    output mem_rd, mem_addr, sfx_ack,
    input  mem_data, sfx_req, sfx_note, sfx_ticks
  );

  modport slave (
    input  mem_rd, mem_addr, sfx_ack,
    output mem_data, sfx_req, sfx_note, sfx_ticks
  );
endinterface

// File: rtl/music_sequencer.sv
// Lead-channel note sequencer with per-note durations, transport control and one preempting SFX.
// Optional: define MUSIC_SEQ_GAP_EN to silence the last TICK_CYCLES/8 cycles of every lead note.
module music_sequencer #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int TICK_FREQ  = 16,
  parameter int ADDR_W     = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               play,
  input  logic               pause,
  input  logic               stop,
  input  logic               loop_en,
  music_seq_if.master        bus,
  output logic [7:0]         note_out,
  output logic               busy,
  output logic               song_done
);

  localparam int TICK_CYCLES = CLOCK_FREQ / TICK_FREQ;
  localparam int PW          = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int IW          = ADDR_W - 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_N, S_LATCH_N, S_FETCH_D, S_LATCH_D, S_PLAY, S_PAUSED
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [7:0]        note_buf_q, note_buf_d;
  logic [7:0]        lead_q, lead_d;
  logic [7:0]        rem_q, rem_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic              pause_pend_q, pause_pend_d;
  logic              sfx_active_q, sfx_active_d;
  logic [7:0]        sfx_note_q, sfx_note_d;
  logic [3:0]        sfx_left_q, sfx_left_d;
  logic [PW-1:0]     sfx_presc_q, sfx_presc_d;
  logic [7:0]        note_out_q, note_out_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              sfx_ack_q, sfx_ack_d;
  logic              song_done_q, song_done_d;
  logic              tick, lead_live, gap;

  // Song transport FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    idx_d        = idx_q;
    note_buf_d   = note_buf_q;
    lead_d       = lead_q;
    rem_d        = rem_q;
    presc_d      = presc_q;
    pause_pend_d = pause_pend_q;
    song_done_d  = 1'b0;
    tick         = (presc_q == TICK_LAST);

    unique case (state_q)
      S_IDLE: begin
        if (play) begin
          idx_d        = '0;
          pause_pend_d = 1'b0;
          state_d      = S_FETCH_N;
        end
      end
      S_FETCH_N: begin
        if (pause) pause_pend_d = 1'b1;
        state_d = S_LATCH_N;
      end
      S_LATCH_N: begin
        if (pause) pause_pend_d = 1'b1;
        if (bus.mem_data == 8'hFF) begin
          if (loop_en) begin
            idx_d   = '0;
            state_d = S_FETCH_N;
          end else begin
            song_done_d = 1'b1;
            state_d     = S_IDLE;
          end
        end else begin
          note_buf_d = bus.mem_data;
          state_d    = S_FETCH_D;
        end
      end
      S_FETCH_D: begin
        if (pause) pause_pend_d = 1'b1;
        state_d = S_LATCH_D;
      end
      S_LATCH_D: begin
        rem_d        = (bus.mem_data == 8'd0) ? 8'd1 : bus.mem_data;
        presc_d      = '0;
        lead_d       = note_buf_q;
        pause_pend_d = 1'b0;
        state_d      = (pause || pause_pend_q) ? S_PAUSED : S_PLAY;
      end
      S_PLAY: begin
        // The cycle in which pause is sampled still counts as played time.
        if (tick) begin
          presc_d = '0;
          if (rem_q == 8'd1) begin
            idx_d   = idx_q + IW'(1);
            state_d = S_FETCH_N;
            if (pause) pause_pend_d = 1'b1;
          end else begin
            rem_d = rem_q - 8'd1;
            if (pause) state_d = S_PAUSED;
          end
        end else begin
          presc_d = presc_q + PW'(1);
          if (pause) state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (play && !pause) state_d = S_PLAY;
      end
      default: state_d = S_IDLE;
    endcase

    if (stop) begin
      state_d      = S_IDLE;
      idx_d        = '0;
      pause_pend_d = 1'b0;
      song_done_d  = 1'b0;
    end
    if (state_d == S_IDLE) lead_d = '0;
  end

  // Sound-effect arbiter with its own tick prescaler.
  always_comb begin
    sfx_active_d = sfx_active_q;
    sfx_note_d   = sfx_note_q;
    sfx_left_d   = sfx_left_q;
    sfx_presc_d  = sfx_presc_q;
    sfx_ack_d    = 1'b0;
    if (!sfx_active_q) begin
      if (bus.sfx_req) begin
        sfx_ack_d    = 1'b1;
        sfx_active_d = 1'b1;
        sfx_note_d   = bus.sfx_note;
        sfx_left_d   = (bus.sfx_ticks == 4'd0) ? 4'd1 : bus.sfx_ticks;
        sfx_presc_d  = '0;
      end
    end else if (sfx_presc_q == TICK_LAST) begin
      sfx_presc_d = '0;
      if (sfx_left_q == 4'd1) sfx_active_d = 1'b0;
      else                    sfx_left_d   = sfx_left_q - 4'd1;
    end else begin
      sfx_presc_d = sfx_presc_q + PW'(1);
    end
  end

  // Outputs are decoded from next-state values so the registers line up with the state.
  always_comb begin
    lead_live = (state_d != S_IDLE) && (state_d != S_PAUSED);
`ifdef MUSIC_SEQ_GAP_EN
    gap = (TICK_CYCLES / 8 > 0) && (state_d == S_PLAY) && (rem_d == 8'd1) &&
          (int'(presc_d) >= TICK_CYCLES - TICK_CYCLES / 8);
`else
    gap = 1'b0;
`endif
    if (sfx_active_d)          note_out_d = sfx_note_d;
    else if (lead_live && !gap) note_out_d = lead_d;
    else                        note_out_d = 8'd0;
    mem_rd_d   = (state_d == S_FETCH_N) || (state_d == S_FETCH_D);
    mem_addr_d = {idx_d, (state_d == S_FETCH_D)};
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      note_buf_q   <= '0;
      lead_q       <= '0;
      rem_q        <= '0;
      presc_q      <= '0;
      pause_pend_q <= 1'b0;
      sfx_active_q <= 1'b0;
      sfx_note_q   <= '0;
      sfx_left_q   <= '0;
      sfx_presc_q  <= '0;
      note_out_q   <= '0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      sfx_ack_q    <= 1'b0;
      song_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      note_buf_q   <= note_buf_d;
      lead_q       <= lead_d;
      rem_q        <= rem_d;
      presc_q      <= presc_d;
      pause_pend_q <= pause_pend_d;
      sfx_active_q <= sfx_active_d;
      sfx_note_q   <= sfx_note_d;
      sfx_left_q   <= sfx_left_d;
      sfx_presc_q  <= sfx_presc_d;
      note_out_q   <= note_out_d;
      mem_rd_q     <= mem_rd_d;
      mem_addr_q   <= mem_addr_d;
      sfx_ack_q    <= sfx_ack_d;
      song_done_q  <= song_done_d;
    end
  end

  assign note_out     = note_out_q;
  assign busy         = (state_q != S_IDLE);
  assign song_done    = song_done_q;
  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.sfx_ack  = sfx_ack_q;

endmodule

// File: doc/music_sequencer.md
Name: music_sequencer

Overview:
- Sequences the lead-channel note stream from the 256-byte song memory and feeds the note code to the wavegen/note-frequency lookup path.
- Replaces the free-running fixed-rate note index with per-note durations, an end-of-song marker, and play/pause/stop/loop control.
- Arbitrates one sound-effect requester that preempts the lead note without disturbing song position.

Parameters:
- CLOCK_FREQ, 50000000: system clock in Hz.
- TICK_FREQ, 16: tempo ticks per second. TICK_CYCLES = CLOCK_FREQ/TICK_FREQ.
- ADDR_W, 8: song memory address width. Entry i occupies addr 2i (note) and 2i+1 (duration in ticks).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- play  in  1  pulse: start from entry 0 (IDLE) or resume (PAUSED)
- pause  in  1  pulse: freeze playback
- stop  in  1  pulse: abort to IDLE
- loop_en  in  1  on end marker, restart instead of finishing
- mem_rd  out  1  read strobe
- mem_addr  out  ADDR_W  read address
- mem_data  in  8  read data, valid exactly 1 cycle after mem_rd
- sfx_req  in  1  sound-effect request level
- sfx_note  in  8  SFX note code (0 = rest)
- sfx_ticks  in  4  SFX length in ticks; 0 is treated as 1
- sfx_ack  out  1  1-cycle pulse when the request is accepted
- note_out  out  8  note code to wavegen; 0 = silence
- busy  out  1  state != IDLE
- song_done  out  1  1-cycle pulse at non-looping end of song

Behaviour:
- Reset values: note_out=0, mem_rd=0, mem_addr=0, sfx_ack=0, song_done=0, busy=0. State=IDLE, entry index=0, SFX inactive, both prescalers=0.
- States: IDLE, FETCH_N, LATCH_N, FETCH_D, LATCH_D, PLAY, PAUSED.
- Control priority: stop > pause > play when pulses coincide in the same cycle.
- IDLE: on play, index=0, go to FETCH_N.
- FETCH_N: mem_rd=1, mem_addr={idx,1'b0}. Go to LATCH_N.
- LATCH_N: capture the note.
  - If note==8'hFF (end marker) and loop_en=1: idx=0, go to FETCH_N.
  - If note==8'hFF and loop_en=0: pulse song_done, go to IDLE.
  - Otherwise go to FETCH_D.
- FETCH_D: mem_rd=1, mem_addr={idx,1'b1}. Go to LATCH_D.
- LATCH_D: remaining=max(mem_data,1). Clear the tick prescaler. Go to PLAY. The lead note register updates on entry to PLAY, 5 cycles after play is sampled.
- PLAY:
  - The prescaler counts 0..TICK_CYCLES-1; a tick fires at TICK_CYCLES-1.
  - When a tick fires with remaining==1: idx=idx+1 (wraps mod 2^(ADDR_W-1)), go to FETCH_N. Otherwise decrement remaining.
  - Each note therefore holds exactly dur*TICK_CYCLES cycles in PLAY.
- During FETCH/LATCH states, note_out holds the previous lead note, giving a glitch-free 4-cycle fetch gap.
- pause:
  - In PLAY: go to PAUSED; prescaler and remaining are frozen; lead output is 0.
  - In a FETCH/LATCH state: the fetch completes, then the block enters PAUSED instead of PLAY.
  - In IDLE: ignored.
- PAUSED: play returns to PLAY with the frozen prescaler and remaining values.
- stop from any state: go to IDLE, idx=0, lead note=0. An in-flight read is discarded.
- SFX arbitration:
  - If sfx_req=1 and no SFX is active, in any state: pulse sfx_ack, latch sfx_note, set sfx_left=max(sfx_ticks,1), start a private SFX prescaler from 0.
  - sfx_req while an SFX is active: no ack; the requester holds sfx_req until acked.
  - An SFX ends after sfx_left*TICK_CYCLES cycles. The next request can be acked on the cycle after it ends.
  - Song timing is independent of SFX and keeps advancing underneath.
- Output mux:
  - SFX active: note_out = SFX note.
  - Else PLAY or FETCH/LATCH: note_out = lead note.
  - Else: note_out = 0.
- Registered outputs: note_out, mem_rd, mem_addr, sfx_ack, song_done.

Optional Feature:
- Macro: MUSIC_SEQ_GAP_EN.
- With it defined: during the final TICK_CYCLES/8 cycles of each lead note (remaining==1 and prescaler >= TICK_CYCLES - TICK_CYCLES/8), the lead output is 0. This articulates repeated notes. SFX output is unaffected.
- Without it: the lead note is held continuously for its full duration.

Test Plan:
- Bench setup: CLOCK_FREQ=40, TICK_FREQ=4 (TICK_CYCLES=10). Memory: [0x10,2, 0x20,1, 0xFF,0]. loop_en=0.
- Basic sequence: play -> note_out=0x10 at cycle 5 for 20 cycles; 0x20 for 10 cycles after a 4-cycle hold; then song_done pulse and note_out=0, busy=0.
- Loop: same memory, loop_en=1 -> after 0x20 the sequence returns to 0x10 with mem_addr=0. song_done never pulses.
- Pause/resume: pause at 7 cycles into 0x10 -> note_out=0 and mem_rd=0 for 50 cycles. play -> 0x10 resumes for the remaining 13 cycles.
- SFX preemption: during 0x10, sfx_req with sfx_note=0x40, sfx_ticks=1 -> one sfx_ack pulse; note_out=0x40 for 10 cycles, then returns to the lead note. Song end time is unchanged.
- Priority and stop: play+pause+stop asserted in the same cycle from PLAY -> IDLE, note_out=0. Duration byte 0 -> the note lasts 10 cycles. With MUSIC_SEQ_GAP_EN, the final 1 cycle of each note reads 0.
